rst_release_seq: RTL and testbench



---
 rtl/rst_release_seq.sv | 118 +++++++++++
 tb/tb_rst_release_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_release_seq.sv
// Staged reset-release sequencer: clock-gate enable, then core reset, then peripheral reset.
// Define RST_SEQ_SW_RST_EN to enable the software warm-reset path (DRAIN state).
module rst_release_seq #(
  parameter int HOLD_CYC  = 4,
  parameter int GATE_DLY  = 2,
  parameter int CORE_DLY  = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_RST_REQ,
  output logic GATE_EN,
  output logic CORE_RST,
  output logic PERIPH_RST,
  output logic SEQ_DONE
);

  localparam int MAX_AB = (HOLD_CYC > GATE_DLY) ? HOLD_CYC : GATE_DLY;
  localparam int MAX_CD = (CORE_DLY > DRAIN_CYC) ? CORE_DLY : DRAIN_CYC;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_DLY - 1);
  localparam logic [CW-1:0] CORE_LAST = CW'(CORE_DLY - 1);
`ifdef RST_SEQ_SW_RST_EN
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
`endif

  typedef enum logic [2:0] {
    HOLD,
    GATE,
    CORE,
    RUN
`ifdef RST_SEQ_SW_RST_EN
    ,
    DRAIN
`endif
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] count, count_next;
  logic          gate_en_d, core_rst_d, periph_rst_d;

`ifndef RST_SEQ_SW_RST_EN
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = SW_RST_REQ;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= HOLD;
      count      <= '0;
      GATE_EN    <= 1'b0;
      CORE_RST   <= 1'b0;
      PERIPH_RST <= 1'b0;
      SEQ_DONE   <= 1'b0;
    end else begin
      state      <= next_state;
      count      <= count_next;
      GATE_EN    <= gate_en_d;
      CORE_RST   <= core_rst_d;
      PERIPH_RST <= periph_rst_d;
      SEQ_DONE   <= periph_rst_d;
    end
  end

  // Each wait state leaves on the edge where the counter reaches its last value.
  always_comb begin
    next_state = state;
    case (state)
      HOLD: if (count == HOLD_LAST) next_state = GATE;
      GATE: if (count == GATE_LAST) next_state = CORE;
      CORE: if (count == CORE_LAST) next_state = RUN;
      RUN: begin
`ifdef RST_SEQ_SW_RST_EN
        if (SW_RST_REQ) next_state = DRAIN;
`endif
      end
`ifdef RST_SEQ_SW_RST_EN
      DRAIN: if (count == DRAIN_LAST) next_state = HOLD;
`endif
      default: next_state = HOLD;
    endcase
  end

  // Counter restarts on every state entry; outputs are decoded from the next state so they land on the transition edge.
  always_comb begin
    count_next   = (next_state != state) ? '0 : count + CW'(1);
    gate_en_d    = 1'b0;
    core_rst_d   = 1'b0;
    periph_rst_d = 1'b0;
    case (next_state)
      GATE: gate_en_d = 1'b1;
      CORE: begin
        gate_en_d  = 1'b1;
        core_rst_d = 1'b1;
      end
      RUN: begin
        gate_en_d    = 1'b1;
        core_rst_d   = 1'b1;
        periph_rst_d = 1'b1;
      end
`ifdef RST_SEQ_SW_RST_EN
      DRAIN: begin
        gate_en_d  = 1'b1;
        core_rst_d = 1'b1;
      end
`endif
      default: begin
        gate_en_d    = 1'b0;
        core_rst_d   = 1'b0;
        periph_rst_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq: default-parameter instance plus an all-ones instance.
// Software-reset scenarios are selected by RST_SEQ_SW_RST_EN to match the RTL build.
module tb_rst_release_seq;

  logic clk;
  logic rst;
  logic sw_req;
  logic sw_req_min;
  logic gate_en, core_rst, periph_rst, seq_done;
  logic gate_en_m, core_rst_m, periph_rst_m, seq_done_m;

  int tests_run;
  int tests_failed;
  bit mon_en;

  rst_release_seq dut (
    .CLK        (clk),
    .RST        (rst),
    .SW_RST_REQ (sw_req),
    .GATE_EN    (gate_en),
    .CORE_RST   (core_rst),
    .PERIPH_RST (periph_rst),
    .SEQ_DONE   (seq_done)
  );

  rst_release_seq #(
    .HOLD_CYC  (1),
    .GATE_DLY  (1),
    .CORE_DLY  (1),
    .DRAIN_CYC (1)
  ) dut_min (
    .CLK        (clk),
    .RST        (rst),
    .SW_RST_REQ (sw_req_min),
    .GATE_EN    (gate_en_m),
    .CORE_RST   (core_rst_m),
    .PERIPH_RST (periph_rst_m),
    .SEQ_DONE   (seq_done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ordering invariants, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      tests_run++;
      if ((periph_rst && !core_rst) || (core_rst && !gate_en) || (seq_done !== periph_rst)) begin
        tests_failed++;
        $display("[TB] FAIL invariant_dflt t=%0t got g/c/p/d=%b%b%b%b", $time, gate_en, core_rst, periph_rst, seq_done);
      end
      tests_run++;
      if ((periph_rst_m && !core_rst_m) || (core_rst_m && !gate_en_m) || (seq_done_m !== periph_rst_m)) begin
        tests_failed++;
        $display("[TB] FAIL invariant_min t=%0t got g/c/p/d=%b%b%b%b", $time, gate_en_m, core_rst_m, periph_rst_m, seq_done_m);
      end
    end
  end

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (7) begin
      @(negedge clk);
      tests_run++;
      if ({gate_en, core_rst, periph_rst, seq_done} !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_dflt got %b expected 0000", {gate_en, core_rst, periph_rst, seq_done});
      end
      tests_run++;
      if ({gate_en_m, core_rst_m, periph_rst_m, seq_done_m} !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_min got %b expected 0000", {gate_en_m, core_rst_m, periph_rst_m, seq_done_m});
      end
    end
    rst = 1'b1;
  endtask

  // Power-up release timing; default edges 4/6/14, all-ones edges 1/2/3.
  task automatic test_power_up();
    logic [3:0] exp_d, exp_m;
    apply_reset(7);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_d = {(e >= 4), (e >= 6), (e >= 14), (e >= 14)};
      exp_m = {(e >= 1), (e >= 2), (e >= 3), (e >= 3)};
      tests_run++;
      if ({gate_en, core_rst, periph_rst, seq_done} !== exp_d) begin
        tests_failed++;
        $display("[TB] FAIL power_up_dflt edge %0d got %b expected %b", e, {gate_en, core_rst, periph_rst, seq_done}, exp_d);
      end
      tests_run++;
      if ({gate_en_m, core_rst_m, periph_rst_m, seq_done_m} !== exp_m) begin
        tests_failed++;
        $display("[TB] FAIL power_up_min edge %0d got %b expected %b", e, {gate_en_m, core_rst_m, periph_rst_m, seq_done_m}, exp_m);
      end
    end
  endtask

  task automatic test_async_abort();
    logic [3:0] exp_d;
    apply_reset(3);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    tests_run++;
    if ({gate_en, core_rst, periph_rst} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL abort_pre got %b expected 100", {gate_en, core_rst, periph_rst});
    end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if ({gate_en, core_rst, periph_rst, seq_done} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL abort_async_dflt got %b expected 0000", {gate_en, core_rst, periph_rst, seq_done});
    end
    tests_run++;
    if ({gate_en_m, core_rst_m, periph_rst_m, seq_done_m} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL abort_async_min got %b expected 0000", {gate_en_m, core_rst_m, periph_rst_m, seq_done_m});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_d = {(e >= 4), (e >= 6), (e >= 14), (e >= 14)};
      tests_run++;
      if ({gate_en, core_rst, periph_rst, seq_done} !== exp_d) begin
        tests_failed++;
        $display("[TB] FAIL abort_restart edge %0d got %b expected %b", e, {gate_en, core_rst, periph_rst, seq_done}, exp_d);
      end
    end
  endtask

  // Request held during edges 2..10 lands outside RUN and must be ignored.
  task automatic test_ignored_request();
    logic [3:0] exp_d;
    apply_reset(3);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_d = {(e >= 4), (e >= 6), (e >= 14), (e >= 14)};
      tests_run++;
      if ({gate_en, core_rst, periph_rst, seq_done} !== exp_d) begin
        tests_failed++;
        $display("[TB] FAIL ignored_req edge %0d got %b expected %b", e, {gate_en, core_rst, periph_rst, seq_done}, exp_d);
      end
      if (e == 1) sw_req = 1'b1;
      if (e == 10) sw_req = 1'b0;
    end
  endtask

`ifdef RST_SEQ_SW_RST_EN
  // One-cycle pulse sampled at edge 20: falls 20/23, re-rises 27/29/37.
  task automatic test_sw_reset();
    logic [3:0] exp_d;
    logic g, c, p;
    apply_reset(3);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      g = ((e >= 4) && (e < 23)) || (e >= 27);
      c = ((e >= 6) && (e < 23)) || (e >= 29);
      p = ((e >= 14) && (e < 20)) || (e >= 37);
      exp_d = {g, c, p, p};
      tests_run++;
      if ({gate_en, core_rst, periph_rst, seq_done} !== exp_d) begin
        tests_failed++;
        $display("[TB] FAIL sw_reset edge %0d got %b expected %b", e, {gate_en, core_rst, periph_rst, seq_done}, exp_d);
      end
      if (e == 19) sw_req = 1'b1;
      if (e == 20) sw_req = 1'b0;
    end
  endtask

  // Held request re-triggers on the first RUN cycle after each release: edges 15 and 33.
  task automatic test_back_to_back();
    logic [3:0] exp_d;
    logic g, c, p;
    apply_reset(3);
    sw_req = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      @(negedge clk);
      g = ((e >= 4) && (e < 18)) || (e >= 22);
      c = ((e >= 6) && (e < 18)) || (e >= 24);
      p = (e == 14) || (e == 32);
      exp_d = {g, c, p, p};
      tests_run++;
      if ({gate_en, core_rst, periph_rst, seq_done} !== exp_d) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back edge %0d got %b expected %b", e, {gate_en, core_rst, periph_rst, seq_done}, exp_d);
      end
    end
    sw_req = 1'b0;
  endtask
`else
  task automatic test_macro_off();
    apply_reset(3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    sw_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({gate_en, core_rst, periph_rst, seq_done} !== 4'b1111) begin
        tests_failed++;
        $display("[TB] FAIL macro_off cycle %0d got %b expected 1111", i, {gate_en, core_rst, periph_rst, seq_done});
      end
    end
    sw_req = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mon_en       = 1'b0;
    rst          = 1'b0;
    sw_req       = 1'b0;
    sw_req_min   = 1'b0;
    #1 mon_en = 1'b1;
    test_reset();
    test_power_up();
    test_async_abort();
    test_ignored_request();
`ifdef RST_SEQ_SW_RST_EN
    test_sw_reset();
    test_back_to_back();
`else
    test_macro_off();
`endif
    @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
